seq_shift_alu: RTL
==================

# seq_shift_alu

Multi-cycle integer execute unit sitting directly downstream of the instruction decoder: consumes the 5-bit `alu_control` code plus two 32-bit operands and produces a 32-bit result with a start/done handshake. Logic/arithmetic ops finish in one cycle. Shifts (SLL/SRL/SRA) use an iterative one-bit-per-cycle shifter unless the barrel shifter is compiled in.

## Interface
- `XLEN`, 32, operand/result width; only 32 is supported.
- `clk`  in  1  system clock, all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  request; sampled only when the unit can accept
- `alu_control`  in  5  operation code from decoder
- `operand_a`  in  XLEN  source 1 / shift value
- `operand_b`  in  XLEN  source 2; bits [4:0] are shift amount for shifts
- `busy`  out  1  high while a shift is iterating; start ignored
- `done`  out  1  one-cycle pulse, result valid
- `result`  out  XLEN  result, held until the next accepted start completes
- `illegal`  out  1  valid with `done`; unsupported `alu_control`

## Operation
- Codes: ADD 00000, SUB 00001, AND 00010, OR 00011, XOR 00100, SLT 00101 (signed), SLTU 00110, SLL 01010, SRL 01011, SRA 01100. Every other code is illegal.
- States: IDLE, SHIFT, DONE.
- Start is accepted in IDLE or DONE when `start`=1. On acceptance, `operand_a`, `operand_b[4:0]` and `alu_control` are latched; later input changes have no effect.
- Non-shift or illegal op: go to DONE next cycle.
  - Result is computed from the latched operands, modulo 2^32; ADD/SUB wrap and no flags are produced.
  - SLT/SLTU return 0 or 1.
  - Illegal: result = 0, `illegal`=1.
- Shift with shamt = 0: go directly to DONE; result = `operand_a`.
- Shift with shamt n > 0: enter SHIFT with counter = n.
  - Each SHIFT cycle shifts the working register by 1 and decrements the counter.
  - SLL fills 0. SRL fills 0. SRA fills with the latched bit 31.
  - When the counter reaches 1 and that cycle's shift completes, go to DONE.
- DONE: `done`=1 for exactly this cycle.
  - Next state is IDLE when `start`=0.
  - When `start`=1, a new op is accepted, which allows back-to-back issue.
- `start` during SHIFT is ignored; the request is dropped, not queued.
- `illegal` is meaningful only when `done`=1; it is 0 in all other states.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `illegal`=0, `result`=0, counter 0.
- Start accepted at edge T:
  - Non-shift, illegal, or shamt 0: `done`=1 in cycle T+1.
  - Shift with n > 0: `busy`=1 for cycles T+1..T+n, `done`=1 at T+n+1. Maximum latency is 32 cycles (n=31).
- `busy` is 0 in IDLE and DONE.
- `result` updates in the same cycle `done` rises and holds until the next `done`.
- Reset asserted mid-SHIFT: next cycle is IDLE with all outputs at reset values. The aborted op never produces `done`.
- Reset and `start` in the same cycle: reset wins and the start is dropped.

## Configuration
- `BARREL_SHIFT_EN` defined:
  - Shifts are computed combinationally and complete like non-shift ops, with `done` at T+1.
  - The SHIFT state is unreachable, `busy` stays 0 and the counter is removed.
- `BARREL_SHIFT_EN` undefined: iterative shifter as described in Operation and Timing.
- Results are identical in both builds; only latency differs.

## Test plan
- ADD, a=5, b=7, start at T -> `done`=1 at T+1, `result`=12, `illegal`=0. SUB, a=0, b=1 -> `result`=0xFFFFFFFF.
- SRA a=0x80000000, b=4 -> `busy` T+1..T+4, `done` at T+5, `result`=0xF8000000. SRL with the same operands -> 0x08000000.
- SLL a=0x1, b=0x20 (shamt 0) -> `done` at T+1, `result`=0x1. SLL a=0x1, b=31 -> `done` at T+32, `result`=0x80000000.
- Issue SRL with n=3, pulse `start` with ADD during SHIFT -> ADD ignored, single `done` with the SRL result. Then ADD 2+2 on the `done` cycle -> accepted, `done` next cycle with result 4.
- Code 5'b11111 -> `done` at T+1, `illegal`=1, `result`=0. SLT a=0xFFFFFFFF, b=1 -> 1; SLTU with the same operands -> 0.
- SRA n=10, assert `rst` at T+4 -> IDLE with `busy`/`done`/`result`=0 the next cycle, no `done` ever. In the `BARREL_SHIFT_EN` build, SRA 0x80000000 by 4 -> `done` at T+1, result 0xF8000000.

Source files
------------

// File: rtl/seq_shift_alu.sv
// seq_shift_alu: multi-cycle integer execute unit with start/done handshake.
// Define BARREL_SHIFT_EN to make shifts single-cycle; default is bit-serial.
module seq_shift_alu #(
   parameter int XLEN = 32
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            start_i,
   input  logic [4:0]      alu_control_i,
   input  logic [XLEN-1:0] operand_a_i,
   input  logic [XLEN-1:0] operand_b_i,
   output logic            busy_o,
   output logic            done_o,
   output logic [XLEN-1:0] result_o,
   output logic            illegal_o
);

   localparam logic [4:0] OP_ADD  = 5'b00000;
   localparam logic [4:0] OP_SUB  = 5'b00001;
   localparam logic [4:0] OP_AND  = 5'b00010;
   localparam logic [4:0] OP_OR   = 5'b00011;
   localparam logic [4:0] OP_XOR  = 5'b00100;
   localparam logic [4:0] OP_SLT  = 5'b00101;
   localparam logic [4:0] OP_SLTU = 5'b00110;
   localparam logic [4:0] OP_SLL  = 5'b01010;
   localparam logic [4:0] OP_SRL  = 5'b01011;
   localparam logic [4:0] OP_SRA  = 5'b01100;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SHIFT = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   logic [1:0]      state_q, state_d;
   logic [XLEN-1:0] result_q, result_d;
   logic            illegal_q, illegal_d;
   logic [XLEN-1:0] alu_res;
   logic            alu_ill;
   logic            accept;
   logic [4:0]      shamt;

   assign shamt  = operand_b_i[4:0];
   assign accept = start_i && (state_q != S_SHIFT);

   // Single-cycle datapath; in the serial build a shift only lands here
   // when its amount is zero, so it just passes operand_a through.
   always_comb begin
      alu_res = '0;
      alu_ill = 1'b0;
      unique case (alu_control_i)
         OP_ADD:  alu_res = operand_a_i + operand_b_i;
         OP_SUB:  alu_res = operand_a_i - operand_b_i;
         OP_AND:  alu_res = operand_a_i & operand_b_i;
         OP_OR:   alu_res = operand_a_i | operand_b_i;
         OP_XOR:  alu_res = operand_a_i ^ operand_b_i;
         OP_SLT:  alu_res = {{(XLEN-1){1'b0}},
                     $signed(operand_a_i) < $signed(operand_b_i)};
         OP_SLTU: alu_res = {{(XLEN-1){1'b0}},
                     operand_a_i < operand_b_i};
`ifdef BARREL_SHIFT_EN
         OP_SLL:  alu_res = operand_a_i << shamt;
         OP_SRL:  alu_res = operand_a_i >> shamt;
         OP_SRA:  alu_res = XLEN'($signed(operand_a_i) >>> shamt);
`else
         OP_SLL:  alu_res = operand_a_i;
         OP_SRL:  alu_res = operand_a_i;
         OP_SRA:  alu_res = operand_a_i;
`endif
         default: alu_ill = 1'b1;
      endcase
   end

`ifdef BARREL_SHIFT_EN
   always_comb begin
      state_d   = (state_q == S_DONE) ? S_IDLE : state_q;
      result_d  = result_q;
      illegal_d = 1'b0;
      if (accept) begin
         state_d   = S_DONE;
         result_d  = alu_res;
         illegal_d = alu_ill;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= S_IDLE;
         result_q  <= '0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         result_q  <= result_d;
         illegal_q <= illegal_d;
      end
   end
`else
   logic [XLEN-1:0] work_q, work_d;
   logic [4:0]      cnt_q, cnt_d;
   logic [4:0]      op_q, op_d;
   logic [XLEN-1:0] work_step;
   logic            is_shift;

   assign is_shift = (alu_control_i == OP_SLL) ||
                     (alu_control_i == OP_SRL) ||
                     (alu_control_i == OP_SRA);

   always_comb begin
      unique case (op_q)
         OP_SLL:  work_step = {work_q[XLEN-2:0], 1'b0};
         OP_SRL:  work_step = {1'b0, work_q[XLEN-1:1]};
         default: work_step = {work_q[XLEN-1], work_q[XLEN-1:1]};
      endcase
   end

   always_comb begin
      state_d   = state_q;
      result_d  = result_q;
      illegal_d = 1'b0;
      work_d    = work_q;
      cnt_d     = cnt_q;
      op_d      = op_q;
      unique case (state_q)
         S_SHIFT: begin
            work_d = work_step;
            cnt_d  = cnt_q - 5'd1;
            if (cnt_q == 5'd1) begin
               state_d  = S_DONE;
               result_d = work_step;
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (accept) begin
         if (is_shift && shamt != 5'd0) begin
            state_d = S_SHIFT;
            work_d  = operand_a_i;
            cnt_d   = shamt;
            op_d    = alu_control_i;
         end else begin
            state_d   = S_DONE;
            result_d  = alu_res;
            illegal_d = alu_ill;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= S_IDLE;
         result_q  <= '0;
         illegal_q <= 1'b0;
         work_q    <= '0;
         cnt_q     <= '0;
         op_q      <= '0;
      end else begin
         state_q   <= state_d;
         result_q  <= result_d;
         illegal_q <= illegal_d;
         work_q    <= work_d;
         cnt_q     <= cnt_d;
         op_q      <= op_d;
      end
   end
`endif

   assign busy_o    = (state_q == S_SHIFT);
   assign done_o    = (state_q == S_DONE);
   assign result_o  = result_q;
   assign illegal_o = illegal_q;

endmodule
